// File: rtl/serial_pkg.sv
// serial_pkg: shared FSM state type, bit-order constants and counter sizing for the serial datapath
package serial_pkg;
  typedef enum logic {IDLE, SHIFT} serial_state_t;
  typedef enum logic {LSB_FIRST = 1'b0, MSB_FIRST = 1'b1} bit_order_e;
  function automatic int cnt_width(input int w);
    return w > 1 ? $clog2(w) : 1;
  endfunction
endpackage

// File: rtl/serial_pair_serializer_if.sv
// serial_pair_serializer_if: operand-pair input handshake and lock-step serial output stream
interface serial_pair_serializer_if #(parameter int W = 16);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_a;
  logic [W-1:0] in_b;
  logic         out_valid;
  logic         out_ready;
  logic         out_a;
  logic         out_b;
  logic         out_first;
  logic         out_last;
  modport master(
    output in_valid, in_a, in_b, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_first, out_last
  );
  modport slave(
    input  in_valid, in_a, in_b, out_ready,
    output in_ready, out_valid, out_a, out_b, out_first, out_last
  );
endinterface

// File: rtl/serial_shift_reg.sv
// serial_shift_reg: W-bit load/shift register presenting its head bit, zero-filled on shift
module serial_shift_reg #(
  parameter int W         = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic         shift_en,
  input  logic [W-1:0] d,
  output logic         head
);
  logic [W-1:0] r_q, r_d;
  always_comb r_d = load ? d : shift_en ? (MSB_FIRST ? r_q << 1 : r_q >> 1) : r_q;
  always_ff @(posedge clk) begin
    if (!rst) r_q <= '0;
    else      r_q <= r_d;
  end
  assign head = MSB_FIRST ? r_q[W-1] : r_q[0];
endmodule

// File: rtl/serial_pair_serializer.sv
// serial_pair_serializer: streams an accepted operand pair as two framed lock-step bit streams
module serial_pair_serializer #(
  parameter int W         = 16,
  parameter bit MSB_FIRST = 1'b1
) (
  input logic                    clk,
  input logic                    rst,
  serial_pair_serializer_if.slave bus
);
  import serial_pkg::*;
  localparam int             CW  = cnt_width(W);
  localparam logic [CW-1:0] TOP = CW'(W - 1);
  serial_state_t state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic shifting, first, last, beat, ready, accept, head_a, head_b;
  // A last beat with a pending pair reloads in place, so words chain without a bubble
  always_comb begin
    shifting = state_q == SHIFT;
    first    = shifting && cnt_q == TOP;
    last     = shifting && cnt_q == '0;
    beat     = shifting && bus.out_ready;
    ready    = rst && (!shifting || (bus.out_ready && last));
    accept   = bus.in_valid && ready;
    state_d  = accept ? SHIFT : (beat && last) ? IDLE : state_q;
    cnt_d    = accept ? TOP : (beat && !last) ? cnt_q - 1'b1 : cnt_q;
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  serial_shift_reg #(.W(W), .MSB_FIRST(MSB_FIRST)) u_sr_a (
    .clk(clk), .rst(rst), .load(accept), .shift_en(beat && !last), .d(bus.in_a), .head(head_a)
  );
  serial_shift_reg #(.W(W), .MSB_FIRST(MSB_FIRST)) u_sr_b (
    .clk(clk), .rst(rst), .load(accept), .shift_en(beat && !last), .d(bus.in_b), .head(head_b)
  );
  assign bus.in_ready  = ready;
  assign bus.out_valid = shifting;
  assign bus.out_a     = shifting && head_a;
  assign bus.out_b     = shifting && head_b;
  assign bus.out_first = first;
  assign bus.out_last  = last;
endmodule

// File: tb/tb_serial_pair_serializer.sv
// tb_serial_pair_serializer: scoreboard bench for MSB-first, LSB-first and single-bit serializers
module tb_serial_pair_serializer;
  localparam int W = 16;
  typedef logic [3:0] obs_t;
  logic clk = 1'b0, rst = 1'b0;
  logic rr_en = 1'b0, rr_rand = 1'b1, dir_ready = 1'b1, stalled = 1'b0;
  int vectors = 0, miscompares = 0;
  obs_t mq[$], lq[$];
  obs_t snap, cur_m, exp_m, cur_l, exp_l;
  serial_pair_serializer_if #(.W(W)) m_if();
  serial_pair_serializer_if #(.W(W)) l_if();
  serial_pair_serializer_if #(.W(1)) s_if();
  serial_pair_serializer #(.W(W), .MSB_FIRST(1'b1)) u_msb (.clk(clk), .rst(rst), .bus(m_if.slave));
  serial_pair_serializer #(.W(W), .MSB_FIRST(1'b0)) u_lsb (.clk(clk), .rst(rst), .bus(l_if.slave));
  serial_pair_serializer #(.W(1), .MSB_FIRST(1'b1)) u_one (.clk(clk), .rst(rst), .bus(s_if.slave));
  assign m_if.out_ready = rr_en ? rr_rand : dir_ready;
  assign l_if.in_valid  = m_if.in_valid;
  assign l_if.in_a      = m_if.in_a;
  assign l_if.in_b      = m_if.in_b;
  assign l_if.out_ready = m_if.out_ready;
  always #5 clk = ~clk;
  always @(posedge clk) begin
    #1;
    rr_rand = ($urandom_range(0, 3) != 0);
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask
  // Reference: bit k of the stream is operand bit W-1-k (MSB-first) or k (LSB-first)
  function automatic void push_word(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int k = 0; k < W; k++) begin
      mq.push_back({a[W-1-k], b[W-1-k], k == 0, k == W - 1});
      lq.push_back({a[k], b[k], k == 0, k == W - 1});
    end
  endfunction
  always @(negedge clk) begin
    if (rst && m_if.out_valid) begin
      cur_m = {m_if.out_a, m_if.out_b, m_if.out_first, m_if.out_last};
      if (stalled) chk("stall_hold", cur_m, snap);
      if (!m_if.out_ready) chk("stall_in_ready", m_if.in_ready, 0);
      else begin
        chk("m_queue_nonempty", mq.size() != 0, 1);
        if (mq.size() != 0) begin
          exp_m = mq.pop_front();
          chk("m_bit", cur_m, exp_m);
        end
      end
      stalled = !m_if.out_ready;
      snap = cur_m;
    end else stalled = 1'b0;
  end
  always @(negedge clk) begin
    if (rst) begin
      chk("l_in_ready", l_if.in_ready, m_if.in_ready);
      if (l_if.out_valid && l_if.out_ready) begin
        cur_l = {l_if.out_a, l_if.out_b, l_if.out_first, l_if.out_last};
        chk("l_queue_nonempty", lq.size() != 0, 1);
        if (lq.size() != 0) begin
          exp_l = lq.pop_front();
          chk("l_bit", cur_l, exp_l);
        end
      end
    end
  end
  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    int t = 0;
    m_if.in_valid = 1'b1;
    m_if.in_a = a;
    m_if.in_b = b;
    @(negedge clk);
    while (!m_if.in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!m_if.in_ready) chk("accept_timeout", m_if.in_ready, 1);
    else push_word(a, b);
    @(posedge clk);
    #1;
    m_if.in_valid = 1'b0;
    m_if.in_a = W'($urandom);
    m_if.in_b = W'($urandom);
  endtask
  task automatic drain();
    for (int t = 0; t < 400 && (mq.size() != 0 || m_if.out_valid); t++) @(negedge clk);
    chk("drain_m", mq.size(), 0);
    chk("drain_l", lq.size(), 0);
    @(posedge clk);
    #1;
  endtask
  task automatic check_idle_zero(input string tag);
    chk({tag, "_valid"}, m_if.out_valid, 0);
    chk({tag, "_outs"}, {m_if.out_a, m_if.out_b, m_if.out_first, m_if.out_last}, 0);
    chk({tag, "_in_ready"}, m_if.in_ready, 0);
  endtask
  initial begin
    logic [1:0] w1_pairs [3];
    int n;
    w1_pairs[0] = 2'b10;
    w1_pairs[1] = 2'b01;
    w1_pairs[2] = 2'b11;
    m_if.in_valid = 1'b0;
    m_if.in_a = '0;
    m_if.in_b = '0;
    s_if.in_valid = 1'b0;
    s_if.in_a = '0;
    s_if.in_b = '0;
    s_if.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_idle_zero("reset");
    chk("reset_w1_in_ready", s_if.in_ready, 0);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("release_in_ready", m_if.in_ready, 1);
    chk("release_w1_in_ready", s_if.in_ready, 1);
    @(posedge clk);
    #1;
    send(16'h6482, 16'h6262);
    drain();
    send(W'($urandom), W'($urandom));
    repeat (4) @(posedge clk);
    #1;
    dir_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    dir_ready = 1'b1;
    drain();
    n = 0;
    fork
      begin
        send(16'hFFFF, 16'h0000);
        send(16'h0001, 16'h0001);
      end
      begin
        for (int t = 0; t < 50 && !m_if.out_valid; t++) @(negedge clk);
        while (m_if.out_valid && n < 40) begin
          n++;
          @(negedge clk);
        end
      end
    join
    chk("b2b_beats", n, 32);
    drain();
    send(W'($urandom), W'($urandom));
    repeat (7) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_idle_zero("midreset");
    mq.delete();
    lq.delete();
    rst = 1'b1;
    @(negedge clk);
    chk("midreset_release_in_ready", m_if.in_ready, 1);
    @(posedge clk);
    #1;
    send(16'hA5C3, 16'h3C5A);
    drain();
    for (int i = 0; i < 3; i++) begin
      s_if.in_valid = 1'b1;
      s_if.in_a = w1_pairs[i][1];
      s_if.in_b = w1_pairs[i][0];
      @(negedge clk);
      chk("w1_in_ready", s_if.in_ready, 1);
      @(posedge clk);
      #1;
      s_if.in_valid = 1'b0;
      s_if.in_a = ~s_if.in_a;
      s_if.in_b = ~s_if.in_b;
      @(negedge clk);
      chk("w1_valid", s_if.out_valid, 1);
      chk("w1_bit", {s_if.out_a, s_if.out_b, s_if.out_first, s_if.out_last}, {w1_pairs[i], 2'b11});
      @(negedge clk);
      chk("w1_idle", s_if.out_valid, 0);
      @(posedge clk);
      #1;
    end
    rr_en = 1'b1;
    repeat (40) begin
      repeat ($urandom_range(0, 2)) @(posedge clk);
      #1;
      send(W'($urandom), W'($urandom));
    end
    rr_en = 1'b0;
    dir_ready = 1'b1;
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/serial_pair_serializer.md
# serial_pair_serializer

Parallel-to-serial front end for the serial comparators. It accepts a pair of W-bit operands through a valid/ready handshake and emits them as two lock-step bit streams, `out_a` and `out_b`, one bit per accepted beat. It sends the most-significant bit first or the least-significant bit first, selected at elaboration time. It marks the first and last bit of each word so downstream logic can frame its comparison.

## Interface
- `W`, default 16: operand width in bits; legal range W >= 1.
- `MSB_FIRST`, default 1: 1 sends bit W-1 first; 0 sends bit 0 first.

- `clk`  in  1  clock; all logic on its rising edge.
- `rst`  in  1  reset, synchronous, active-low: asserted when 0, sampled only on the rising edge of `clk`.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  serializer can take a pair this cycle.
- `in_a`  in  W  operand A.
- `in_b`  in  W  operand B.
- `out_valid`  out  1  `out_a`/`out_b` hold a valid bit.
- `out_ready`  in  1  downstream consumes the current bit.
- `out_a`  out  1  current bit of A.
- `out_b`  out  1  current bit of B.
- `out_first`  out  1  current bit is the first bit of its word.
- `out_last`  out  1  current bit is the last bit of its word.

## Operation
- States: IDLE and SHIFT.
- IDLE: `in_ready`=1 and `out_valid`=0. When `in_valid`=1, the pair is captured into shift registers A and B, the bit counter is set to W-1, and the state moves to SHIFT.
- SHIFT: `out_valid`=1.
  - `out_a`/`out_b` are the head bits of the shift registers.
  - `out_first`=1 when counter = W-1.
  - `out_last`=1 when counter = 0.
- On a beat (`out_valid` & `out_ready`):
  - Not last: both registers shift toward the head and the counter decrements.
  - Last: if `in_valid`=1, the new pair loads and SHIFT continues with no bubble. Otherwise the state returns to IDLE.
- `in_ready` = IDLE | (SHIFT & `out_ready` & `out_last`). It is combinational from state and `out_ready`, and is forced to 0 while `rst`=0.
- Backpressure: while `out_valid`=1 and `out_ready`=0, every output holds stable and no state changes.
- W=1: the single bit has `out_first`=`out_last`=1.
- Width rules:
  - The counter is max(1, $clog2(W)) bits wide and never wraps below 0.
  - The shift registers are exactly W bits; the bit shifted in is 0.
- `in_a`/`in_b` are sampled only on the accept edge; later changes have no effect.

## Timing
- Reset values (registered): state=IDLE, `out_valid`=0, `out_a`=0, `out_b`=0, `out_first`=0, `out_last`=0, counter=0.
- `in_ready`=1 in the first cycle after `rst` returns to 1.
- Latency: a pair accepted at edge t presents its first bit after edge t; a word occupies W beats.
- Throughput is one bit per cycle with `out_ready` held at 1. Back-to-back words have zero idle cycles.
- Reset mid-word: a synchronous reset edge aborts the word. The partial word is discarded and never resumed, and the next cycle shows reset values.
- Simultaneous last beat and new `in_valid`: the new word's first bit appears on the next cycle with `out_first`=1.

## Structure
- Package `serial_pkg` holds the state typedef (`serial_state_t`: IDLE, SHIFT) and a `bit_order_e` constant pair (LSB_FIRST=0, MSB_FIRST=1). The serial comparators share this package.
- One sub-module, `serial_shift_reg`, takes parameters W and MSB_FIRST and provides load, shift-enable and head-bit output. It is instantiated twice, once for A and once for B.
- The counter and the FSM live in the top module.

## Test plan
- MSB_FIRST=1, W=16, `in_a`=16'h6482, `in_b`=16'h6262, `out_ready`=1:
  - `out_a` = 0110_0100_1000_0010 and `out_b` = 0110_0010_0110_0010 over 16 cycles.
  - `out_first` only on cycle 1 and `out_last` only on cycle 16.
  - Chained to the MSB-first comparator, the comparator reports greater from bit 6 onward.
- MSB_FIRST=0, same operands: `out_a` = 0100_0001_0010_0110, i.e. the operand reversed.
- Backpressure: hold `out_ready`=0 for 3 cycles at bit 5. Outputs stay frozen, the word still completes with 16 beats total, and `in_ready` stays 0 throughout.
- Back-to-back: `in_valid` held high with pairs 16'hFFFF/16'h0000 then 16'h0001/16'h0001. Exactly 32 consecutive valid beats, with `out_first` on beats 1 and 17.
- Reset mid-word: drive `rst`=0 for one edge at bit 8. All outputs read 0 the next cycle, `in_ready`=1 after release, and a new pair serializes correctly from its first bit.
- W=1, pair 1/0: one beat with `out_a`=1, `out_b`=0 and `out_first`=`out_last`=1, then IDLE.
